pipo_load_arbiter: RTL and testbench

Round-robin load controller that shares one N-bit PIPO register between R requesters. Each requester offers a data word with a level request. The block picks one winner, drives the word and a one-cycle load strobe to the register, then acknowledges that requester with a four-phase handshake. It sits directly in front of the PIPO register's data input and owns that register's load enable.

---
 rtl/pipo_load_arbiter.sv | 124 ++++++++++++
 tb/tb_pipo_load_arbiter.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/pipo_load_arbiter.sv
// Round-robin load controller: one winner per IDLE edge drives a shared PIPO register,
// then receives a one-cycle ack and a four-phase release. All outputs are registered.
module pipo_load_arbiter #(
   parameter int unsigned N  = 4,
   parameter int unsigned R  = 4,
   parameter int unsigned CW = 8
) (
   input  logic            clk,
   input  logic            reset_al_in,
   input  logic [R-1:0]    req_in,
   input  logic [R*N-1:0]  data_in,
   output logic [R-1:0]    grant_out,
   output logic [N-1:0]    d_out,
   output logic            load_out,
   output logic [R-1:0]    ack_out,
   output logic            busy_out,
   output logic [CW-1:0]   load_count_out
);

   localparam int unsigned PW = (R > 1) ? $clog2(R) : 1;

   typedef enum logic [1:0] {IDLE, LOAD, ACK, RELEASE} state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] ptr_q, ptr_d;
   logic [PW-1:0] win_q, win_d;
   logic [R-1:0]  grant_q, grant_d;
   logic [N-1:0]  d_q, d_d;
   logic          load_q, load_d;
   logic [R-1:0]  ack_q, ack_d;
   logic          busy_q, busy_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic          found;
   logic [PW-1:0] pick;
   int unsigned   idx;

   // First requester at or after ptr, scanning modulo R.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      idx   = 0;
      for (int unsigned i = 0; i < R; i++) begin
         idx = (ptr_q + i) % R;
         if (!found && req_in[idx]) begin
            found = 1'b1;
            pick  = PW'(idx);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_al_in) begin
      if (!reset_al_in) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         win_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         win_q   <= win_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      win_d   = win_q;
      case (state_q)
         IDLE: begin
            if (found) begin
               state_d = LOAD;
               win_d   = pick;
               ptr_d   = (pick == PW'(R-1)) ? '0 : pick + 1'b1;
            end
         end
         LOAD:    state_d = ACK;
         ACK:     state_d = RELEASE;
         RELEASE: if (!req_in[win_q]) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output values are computed for the upcoming state so they register cleanly.
   always_comb begin
      grant_d = grant_q;
      d_d     = d_q;
      cnt_d   = cnt_q;
      if (state_q == IDLE && found) begin
         grant_d = R'(1) << pick;
         d_d     = data_in[pick*N +: N];
      end
      if (state_q == RELEASE && state_d == IDLE) grant_d = '0;
      if (state_q == ACK) cnt_d = cnt_q + 1'b1;
      load_d = (state_d == LOAD);
      ack_d  = (state_d == ACK) ? grant_q : '0;
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge reset_al_in) begin
      if (!reset_al_in) begin
         grant_q <= '0;
         d_q     <= '0;
         load_q  <= 1'b0;
         ack_q   <= '0;
         busy_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         grant_q <= grant_d;
         d_q     <= d_d;
         load_q  <= load_d;
         ack_q   <= ack_d;
         busy_q  <= busy_d;
         cnt_q   <= cnt_d;
      end
   end

   assign grant_out      = grant_q;
   assign d_out          = d_q;
   assign load_out       = load_q;
   assign ack_out        = ack_q;
   assign busy_out       = busy_q;
   assign load_count_out = cnt_q;

endmodule

// File: tb/tb_pipo_load_arbiter.sv
// Scoreboard bench for pipo_load_arbiter (N=4, R=4, CW=2): directed transactions push
// expected load/ack responses; a monitor pops and compares whenever the DUT strobes.
module tb_pipo_load_arbiter;

   logic        clk = 1'b0;
   logic        reset_al_in;
   logic [3:0]  req_in;
   logic [15:0] data_in;
   logic [3:0]  grant_out;
   logic [3:0]  d_out;
   logic        load_out;
   logic [3:0]  ack_out;
   logic        busy_out;
   logic [1:0]  load_count_out;

   int checks = 0;
   int errors = 0;
   logic [1:0] exp_cnt = 2'd0;

   logic [7:0]  lq[$];   // {grant, d}
   logic [13:0] aq[$];   // {ack, grant, d, count during ack}

   pipo_load_arbiter #(.N(4), .R(4), .CW(2)) dut (
      .clk            (clk),
      .reset_al_in    (reset_al_in),
      .req_in         (req_in),
      .data_in        (data_in),
      .grant_out      (grant_out),
      .d_out          (d_out),
      .load_out       (load_out),
      .ack_out        (ack_out),
      .busy_out       (busy_out),
      .load_count_out (load_count_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Monitor: compare every load strobe and ack pulse against the scoreboard.
   always @(posedge clk) begin
      #1;
      if (load_out === 1'b1) begin
         if (lq.size() == 0) chk("unexpected_load", 32'd1, 32'd0);
         else chk("load", {grant_out, d_out}, lq.pop_front());
      end
      if (ack_out !== 4'b0000) begin
         if (aq.size() == 0) chk("unexpected_ack", {28'd0, ack_out}, 32'd0);
         else chk("ack", {ack_out, grant_out, d_out, load_count_out}, aq.pop_front());
      end
   end

   // hold < 0: drop during LOAD; otherwise drop hold cycles after the ack cycle.
   task automatic run_txn(input int w, input logic [3:0] dw, input int hold,
                          input bit reraise, input bit scramble);
      logic [3:0] oh;
      int ackn;
      int lat;
      bit acked, dropped, done;
      oh = 4'b0001 << w;
      lq.push_back({oh, dw});
      aq.push_back({oh, oh, dw, exp_cnt});
      exp_cnt = exp_cnt + 2'd1;
      acked = 0; dropped = 0; done = 0; ackn = 0;
      lat = (hold + 1 > 2) ? hold + 1 : 2;
      for (int n = 0; n < 20 && !done; n++) begin
         @(negedge clk);
         if (load_out) begin
            if (scramble) data_in[w*4 +: 4] = ~dw;
            if (hold < 0) begin req_in[w] = 1'b0; dropped = 1; end
         end
         if (acked) begin
            ackn++;
            if (!dropped) chk("grant_hold", {28'd0, grant_out}, {28'd0, oh});
         end
         if (ack_out != 4'b0000) acked = 1;
         if (acked && !dropped && ackn == (hold < 0 ? 0 : hold)) begin
            req_in[w] = 1'b0;
            dropped = 1;
         end
         if (acked && dropped && !busy_out) begin
            done = 1;
            chk("exit_latency", ackn, lat);
         end
      end
      if (!done) chk("txn_timeout", 32'd0, 32'd1);
      chk("count", {30'd0, load_count_out}, {30'd0, exp_cnt});
      chk("idle_grant", {28'd0, grant_out}, 32'd0);
      if (reraise) req_in[w] = 1'b1;
   endtask

   initial begin
      bit seen;
      reset_al_in = 1'b0;
      req_in  = 4'b1111;
      data_in = {4'h8, 4'h7, 4'h6, 4'h5};
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("reset_outputs", {grant_out, d_out, load_out, ack_out, busy_out, load_count_out}, 32'd0);
      end
      reset_al_in = 1'b1;

      // Round-robin with all requests held; count wraps 1,2,3,0,1.
      run_txn(0, 4'h5, 0, 1, 0);
      run_txn(1, 4'h6, 0, 1, 0);
      run_txn(2, 4'h7, 0, 1, 0);
      run_txn(3, 4'h8, 0, 1, 0);
      run_txn(0, 4'h5, 0, 1, 0);
      req_in = 4'b0000;

      // Single request held past ack; lane changes during LOAD must not reach d_out.
      @(negedge clk);
      data_in[11:8] = 4'hA;
      req_in = 4'b0100;
      run_txn(2, 4'hA, 3, 0, 1);

      // Early drop during LOAD.
      data_in[7:4] = 4'hC;
      req_in = 4'b0010;
      run_txn(1, 4'hC, -1, 0, 0);

      // Simultaneous requests: ptr=2 so requester 3 wins, then 0.
      data_in[3:0]   = 4'h1;
      data_in[15:12] = 4'hE;
      req_in = 4'b1001;
      run_txn(3, 4'hE, 0, 0, 0);
      run_txn(0, 4'h1, 0, 0, 0);

      // Reset during ACK aborts the transaction and clears ptr.
      data_in[3:0] = 4'h9;
      req_in = 4'b0001;
      lq.push_back({4'b0001, 4'h9});
      aq.push_back({4'b0001, 4'b0001, 4'h9, exp_cnt});
      seen = 0;
      for (int n = 0; n < 10 && !seen; n++) begin
         @(negedge clk);
         if (ack_out != 4'b0000) seen = 1;
      end
      if (!seen) chk("ack_timeout", 32'd0, 32'd1);
      reset_al_in = 1'b0;
      #1;
      chk("midreset_outputs", {grant_out, d_out, load_out, ack_out, busy_out, load_count_out}, 32'd0);
      exp_cnt = 2'd0;
      req_in = 4'b0011;
      @(negedge clk);
      reset_al_in = 1'b1;
      run_txn(0, 4'h9, 0, 0, 0);
      run_txn(1, 4'hC, 0, 0, 0);

      repeat (3) @(negedge clk);
      chk("lq_drained", lq.size(), 32'd0);
      chk("aq_drained", aq.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
